alu_ctrl_exec: RTL and testbench

//  Parametrised successor to the combinational ALU-control decoder. Decodes aluop/funct into the
//  3-bit ALU control, executes the operation on WIDTH-bit operands, and returns a registered result.

---
 rtl/alu_ctrl_exec.sv | 168 ++++++++++++++++
 tb/tb_alu_ctrl_exec.sv | 257 +++++++++++++++++++++++++
 2 files changed

// File: rtl/alu_ctrl_exec.sv
// -----------------------------------------------------------------------------
// alu_ctrl_exec
//   ALU control decoder plus execution unit with a registered result.
//   The aluop/funct pair is decoded into a 3-bit ALU control code and the
//   operation runs on WIDTH-bit operands. Non-shift operations, and shifts by
//   zero, complete in one cycle. Other shifts move one bit per cycle.
//   The unit uses valid/ready handshakes on both the request side and the
//   result side.
//
// Ports
//   clk        rising-edge clock
//   reset      synchronous, active-high reset
//   in_valid   request valid
//   in_ready   request accepted this cycle if in_valid (high only when idle)
//   aluop      00 add, 01 sub, 10 R-type (use funct), 11 xor
//   funct      R-type function code
//   a, b       operands (a is the shift source; b is ignored by shifts)
//   shamt      shift amount
//   out_valid  result valid, held until out_ready
//   out_ready  consumer accepts the result
//   result     registered result
//   zero       result == 0
//   gout       registered ALU control code of the captured operation
//   err        funct was not in the R-type table; the operation ran as add
// -----------------------------------------------------------------------------
module alu_ctrl_exec #(
    parameter int WIDTH   = 32,
    parameter int SHAMT_W = 5
) (
    input  logic               clk,
    input  logic               reset,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [1:0]         aluop,
    input  logic [3:0]         funct,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [SHAMT_W-1:0] shamt,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   result,
    output logic               zero,
    output logic [2:0]         gout,
    output logic               err
);

    // The execute state is folded into the accept cycle. Single-cycle
    // operations therefore go straight from IDLE to DONE.
    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_SHIFT = 2'd1;
    localparam logic [1:0] ST_DONE  = 2'd2;

    localparam logic [2:0] CTRL_AND = 3'b000;
    localparam logic [2:0] CTRL_OR  = 3'b001;
    localparam logic [2:0] CTRL_ADD = 3'b010;
    localparam logic [2:0] CTRL_XOR = 3'b011;
    localparam logic [2:0] CTRL_SRL = 3'b100;
    localparam logic [2:0] CTRL_SLL = 3'b101;
    localparam logic [2:0] CTRL_SUB = 3'b110;
    localparam logic [2:0] CTRL_SLT = 3'b111;

    logic [1:0]         state;
    logic [SHAMT_W-1:0] count;
    logic [2:0]         dec_ctrl;
    logic               dec_err;
    logic [WIDTH-1:0]   exec_val;
    logic               is_shift;
    logic               accept;

    assign in_ready  = (state == ST_IDLE);
    assign out_valid = (state == ST_DONE);
    assign zero      = (result == '0);
    assign accept    = in_valid & in_ready;

    // NOTE: every signal assigned in always_comb gets a default first.
    // Otherwise an incomplete case infers a latch.
    always_comb begin
        dec_ctrl = CTRL_ADD;
        dec_err  = 1'b0;
        case (aluop)
            2'b00: dec_ctrl = CTRL_ADD;
            2'b01: dec_ctrl = CTRL_SUB;
            2'b11: dec_ctrl = CTRL_XOR;
            default: begin
                case (funct)
                    4'b0000: dec_ctrl = CTRL_ADD;
                    4'b0100: dec_ctrl = CTRL_AND;
                    4'b0101: dec_ctrl = CTRL_OR;
                    4'b0110: dec_ctrl = CTRL_SUB;
                    4'b0111: dec_ctrl = CTRL_XOR;
                    4'b1010: dec_ctrl = CTRL_SLT;
                    4'b0010: dec_ctrl = CTRL_SRL;
                    4'b0011: dec_ctrl = CTRL_SLL;
                    default: begin
                        dec_ctrl = CTRL_ADD;
                        dec_err  = 1'b1;
                    end
                endcase
            end
        endcase
    end

    assign is_shift = (dec_ctrl == CTRL_SRL) || (dec_ctrl == CTRL_SLL);

    // Single-cycle result. For shifts this value is only used when shamt is
    // zero, so a passes through unchanged.
    always_comb begin
        exec_val = '0;
        case (dec_ctrl)
            CTRL_AND: exec_val = a & b;
            CTRL_OR:  exec_val = a | b;
            CTRL_ADD: exec_val = a + b;
            CTRL_XOR: exec_val = a ^ b;
            CTRL_SUB: exec_val = a - b;
            CTRL_SLT: exec_val = {{(WIDTH-1){1'b0}}, ($signed(a) < $signed(b))};
            default:  exec_val = a;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments. Every register
    // then updates from the values that existed before the clock edge.
    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= ST_IDLE;
            count  <= '0;
            result <= '0;
            gout   <= CTRL_ADD;
            err    <= 1'b0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (accept) begin
                        gout <= dec_ctrl;
                        err  <= dec_err;
                        if (is_shift && (shamt != '0)) begin
                            // result doubles as the shift register.
                            result <= a;
                            count  <= shamt;
                            state  <= ST_SHIFT;
                        end else begin
                            result <= exec_val;
                            state  <= ST_DONE;
                        end
                    end
                end
                ST_SHIFT: begin
                    if (gout == CTRL_SRL) begin
                        result <= {1'b0, result[WIDTH-1:1]};
                    end else begin
                        result <= {result[WIDTH-2:0], 1'b0};
                    end
                    count <= count - SHAMT_W'(1);
                    // The last bit moves in this cycle.
                    if (count == SHAMT_W'(1)) begin
                        state <= ST_DONE;
                    end
                end
                ST_DONE: begin
                    if (out_ready) begin
                        state <= ST_IDLE;
                    end
                end
                default: state <= ST_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_ctrl_exec.sv
// -----------------------------------------------------------------------------
// tb_alu_ctrl_exec
//   Self-checking bench for alu_ctrl_exec (WIDTH=32, SHAMT_W=5).
//   When a request is accepted, the driver pushes the expected response into
//   a queue. The monitor pops that entry on the first out_valid cycle. It then
//   checks value, latency, hold stability and in_ready on every cycle.
// -----------------------------------------------------------------------------
module tb_alu_ctrl_exec;

    logic        clk = 1'b0;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [3:0]  funct;
    logic [31:0] a, b;
    logic [4:0]  shamt;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic [2:0]  gout;
    logic        err;

    alu_ctrl_exec #(.WIDTH(32), .SHAMT_W(5)) dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .a(a), .b(b), .shamt(shamt),
        .out_valid(out_valid), .out_ready(out_ready), .result(result),
        .zero(zero), .gout(gout), .err(err)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [31:0] res;
        logic [2:0]  ctrl;
        logic        err;
        int          cyc;   // cycle in which out_valid must first be seen
    } exp_t;

    exp_t q[$];
    exp_t cur;
    bit   seen = 1'b0;
    bit   mon_en = 1'b0;
    bit   rand_rdy = 1'b0;
    int   cyc = 0;
    int   n_checks = 0;
    int   n_errors = 0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model. It takes the control code from the decode table and
    // computes the final value in one step, including the full shift.
    function automatic exp_t model(input logic [1:0] op, input logic [3:0] f,
                                   input logic [31:0] x, input logic [31:0] y,
                                   input logic [4:0] sh);
        exp_t e;
        e.err = 1'b0;
        case (op)
            2'b00: e.ctrl = 3'b010;
            2'b01: e.ctrl = 3'b110;
            2'b11: e.ctrl = 3'b011;
            default:
                case (f)
                    4'b0000: e.ctrl = 3'b010;
                    4'b0100: e.ctrl = 3'b000;
                    4'b0101: e.ctrl = 3'b001;
                    4'b0110: e.ctrl = 3'b110;
                    4'b0111: e.ctrl = 3'b011;
                    4'b1010: e.ctrl = 3'b111;
                    4'b0010: e.ctrl = 3'b100;
                    4'b0011: e.ctrl = 3'b101;
                    default: begin e.ctrl = 3'b010; e.err = 1'b1; end
                endcase
        endcase
        case (e.ctrl)
            3'b000:  e.res = x & y;
            3'b001:  e.res = x | y;
            3'b010:  e.res = x + y;
            3'b011:  e.res = x ^ y;
            3'b110:  e.res = x - y;
            3'b111:  e.res = ($signed(x) < $signed(y)) ? 32'd1 : 32'd0;
            3'b100:  e.res = x >> sh;
            default: e.res = x << sh;
        endcase
        e.cyc = ((e.ctrl == 3'b100 || e.ctrl == 3'b101) && sh != 0) ? int'(sh) + 1 : 1;
        return e;
    endfunction

    // Monitor: samples on the falling edge, between input updates.
    always @(negedge clk) begin
        if (!reset && mon_en) begin
            check("in_ready", {31'd0, in_ready}, {31'd0, (q.size() == 0 && !seen)});
            if (out_valid) begin
                if (!seen) begin
                    if (q.size() == 0) begin
                        n_checks++;
                        n_errors++;
                        $display("FAIL unexpected_out_valid: got 1 expected 0 (cycle %0d)", cyc);
                    end else begin
                        cur  = q.pop_front();
                        seen = 1'b1;
                        check("latency_cycle", cyc, cur.cyc);
                    end
                end
                if (seen) begin
                    check("result", result, cur.res);
                    check("gout", {29'd0, gout}, {29'd0, cur.ctrl});
                    check("err", {31'd0, err}, {31'd0, cur.err});
                    check("zero", {31'd0, zero}, {31'd0, (cur.res == 32'd0)});
                    if (out_ready) seen = 1'b0;
                end
            end
        end
    end

    // Random consumer back-pressure, active only during the random phase.
    always @(posedge clk) begin
        #1;
        if (rand_rdy) out_ready = ($urandom_range(0, 3) != 0);
    end

    // Presents one request and holds it until it is accepted. With jitter
    // set, operands change on each cycle the unit is busy, and those values
    // must be ignored. The call is made, and returns, 1 time unit after a
    // rising edge.
    task automatic issue(input logic [1:0] op, input logic [3:0] f, input logic [31:0] x,
                         input logic [31:0] y, input logic [4:0] sh, input bit jitter);
        bit done = 1'b0;
        int waited = 0;
        exp_t e;
        in_valid = 1'b1;
        aluop = op; funct = f; a = x; b = y; shamt = sh;
        while (!done) begin
            @(negedge clk); #1;
            if (in_ready) begin
                e = model(aluop, funct, a, b, shamt);
                e.cyc = e.cyc + cyc;
                q.push_back(e);
                done = 1'b1;
            end
            @(posedge clk); #1;
            if (!done) begin
                waited++;
                if (jitter) begin a = $urandom; b = $urandom; end
                if (waited > 200) begin
                    n_checks++;
                    n_errors++;
                    $display("FAIL accept_timeout: got busy expected accept within 200 cycles");
                    done = 1'b1;
                end
            end
        end
        in_valid = 1'b0;
        // Changes after accept must not affect the operation in flight.
        aluop = 2'($urandom); funct = 4'($urandom);
        a = $urandom; b = $urandom; shamt = 5'($urandom);
    endtask

    task automatic drain();
        int n = 0;
        while ((q.size() != 0 || seen) && n < 500) begin
            @(posedge clk);
            n++;
        end
        if (n >= 500) begin
            n_checks++;
            n_errors++;
            $display("FAIL drain_timeout: got %0d pending expected 0", q.size());
        end
        @(posedge clk); #1;
    endtask

    initial begin
        logic [3:0] functs [8];
        functs = '{4'b0000, 4'b0100, 4'b0101, 4'b0110, 4'b0111, 4'b1010, 4'b0010, 4'b0011};

        reset = 1'b1; in_valid = 1'b0; out_ready = 1'b1;
        aluop = 2'b00; funct = 4'd0; a = '0; b = '0; shamt = '0;
        repeat (3) @(posedge clk);
        #1 reset = 1'b0;
        check("rst_in_ready", {31'd0, in_ready}, 32'd1);
        check("rst_out_valid", {31'd0, out_valid}, 32'd0);
        check("rst_result", result, 32'd0);
        check("rst_gout", {29'd0, gout}, 32'd2);
        check("rst_zero", {31'd0, zero}, 32'd1);
        check("rst_err", {31'd0, err}, 32'd0);
        mon_en = 1'b1;

        // Add, signed compare both ways, srl by 4.
        issue(2'b10, 4'b0000, 32'd5, 32'd7, 5'd0, 1'b0);
        issue(2'b10, 4'b1010, -32'sd3, 32'd2, 5'd0, 1'b0);
        issue(2'b10, 4'b1010, 32'd2, -32'sd3, 5'd0, 1'b0);
        issue(2'b10, 4'b0010, 32'h8000_0000, 32'd0, 5'd4, 1'b0);
        issue(2'b10, 4'b0011, 32'h0000_0001, 32'd0, 5'd31, 1'b0);
        issue(2'b10, 4'b0011, 32'h1234_5678, 32'd0, 5'd0, 1'b0);
        // Unknown funct, then sub to zero.
        issue(2'b10, 4'b1111, 32'd1, 32'd1, 5'd0, 1'b0);
        issue(2'b01, 4'b0000, 32'd9, 32'd9, 5'd0, 1'b0);
        issue(2'b11, 4'b0000, 32'hF0F0_F0F0, 32'hFFFF_0000, 5'd0, 1'b0);
        drain();

        // Result held for 3 cycles under back-pressure.
        out_ready = 1'b0;
        issue(2'b10, 4'b0100, 32'hDEAD_BEEF, 32'h0F0F_0F0F, 5'd0, 1'b0);
        begin
            int n = 0;
            while (!out_valid && n < 50) begin @(negedge clk); n++; end
        end
        repeat (3) @(posedge clk);
        #1 out_ready = 1'b1;
        drain();

        // Reset in the middle of a 20-bit shift.
        issue(2'b10, 4'b0010, 32'hFFFF_FFFF, 32'd0, 5'd20, 1'b0);
        repeat (4) @(posedge clk);
        #1 reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        q.delete();
        seen = 1'b0;
        check("midrst_out_valid", {31'd0, out_valid}, 32'd0);
        check("midrst_result", result, 32'd0);
        check("midrst_in_ready", {31'd0, in_ready}, 32'd1);
        check("midrst_gout", {29'd0, gout}, 32'd2);
        check("midrst_zero", {31'd0, zero}, 32'd1);
        issue(2'b00, 4'b0000, 32'hFFFF_FFFF, 32'd1, 5'd0, 1'b0);
        drain();

        // Random phase.
        rand_rdy = 1'b1;
        for (int i = 0; i < 300; i++) begin
            logic [1:0] op;
            logic [3:0] f;
            op = 2'($urandom);
            f  = ($urandom_range(0, 4) == 0) ? 4'($urandom) : functs[$urandom_range(0, 7)];
            issue(op, f, $urandom, $urandom, 5'($urandom), 1'b1);
            repeat ($urandom_range(0, 2)) @(posedge clk);
            #1;
        end
        rand_rdy = 1'b0;
        #1 out_ready = 1'b1;
        drain();

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
